// File: rtl/fetch_req_tracker_pkg.sv
// Shared definitions for the fetch request tracker: sizing constants, the
// in-flight entry record and small helper functions.
package fetch_req_tracker_pkg;

    localparam int NUM_WF  = 40;
    localparam int WF_ID_W = 6;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;

    // Count value meaning "every slot occupied".
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [WF_ID_W-1:0] wfid;
        logic [PC_W-1:0]    pc;
        logic               killed;
    } fetch_entry_t;

    // True when the ID addresses an existing wavefront slot.
    function automatic logic wfid_in_range(input logic [WF_ID_W-1:0] wfid);
        return (int'(wfid) < NUM_WF);
    endfunction

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/fetch_req_tracker_fifo.sv
// In-order store of outstanding icache requests. Owns entry storage,
// read/write pointers, occupancy count and the kill-by-wfid marking used
// when a wavefront is flushed while its fetch is still in flight.
module fetch_tracker_fifo
    import fetch_req_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush_valid,
    input  logic [WF_ID_W-1:0] flush_wfid,
    output fetch_entry_t       head_entry,
    output logic [PTR_W:0]     count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic               push_s;
    logic               pop_s;

    assign full       = (count_r == DEPTH_CNT);
    assign empty      = (count_r == {(PTR_W + 1){1'b0}});
    assign push_s     = push & ~full;
    assign pop_s      = pop & ~empty;
    assign head_entry = mem_r[rd_ptr_r];
    assign count      = count_r;

    // Entry storage with associative kill. Marking a free slot is harmless:
    // a later push overwrites the whole record with killed cleared, and a
    // push never targets a live slot, so the two writes cannot collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_valid && (mem_r[i].wfid == flush_wfid)) begin
                    mem_r[i].killed <= 1'b1;
                end
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
            end
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_req_tracker.sv
// Fetch request tracker: sits between the fetch arbiter and the icache.
// Accepts one wavefront fetch per cycle, issues the icache read one cycle
// later, tags in-order icache returns with their wavefront, drops returns
// of flushed wavefronts and reports a pending mask plus credit to the
// arbiter. Optional macro FETCH_TRACK_PERF_EN adds saturating performance
// counters (perf_issued, perf_killed, perf_stall).
module fetch_req_tracker
    import fetch_req_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid,
    input  logic [WF_ID_W-1:0] fetch_wfid,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic               fetch_accept,
    output logic               credit_ok,
    output logic [NUM_WF-1:0]  pending_mask,
    output logic               icache_rd_en,
    output logic [PC_W-1:0]    icache_rd_addr,
    input  logic               icache_ack,
    input  logic               flush_valid,
    input  logic [WF_ID_W-1:0] flush_wfid,
    output logic               inst_valid,
    output logic [WF_ID_W-1:0] inst_wfid,
    output logic [PC_W-1:0]    inst_pc,
    output logic               ack_err
`ifdef FETCH_TRACK_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_killed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int WF_SPACE = 1 << WF_ID_W;

    logic [NUM_WF-1:0]   pending_r;
    logic [WF_SPACE-1:0] pending_ext_s;
    logic                rd_en_r;
    logic [PC_W-1:0]     rd_addr_r;
    logic                inst_valid_r;
    logic [WF_ID_W-1:0]  inst_wfid_r;
    logic [PC_W-1:0]     inst_pc_r;
    logic                ack_err_r;

    logic                accept_s;
    logic                pop_s;
    logic                head_killed_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [PTR_W:0]      fifo_count_s;
    fetch_entry_t        head_s;
    fetch_entry_t        push_entry_s;

    // Zero-extended view so any 6-bit ID indexes a real bit (IDs >= NUM_WF read 0).
    assign pending_ext_s = {{(WF_SPACE - NUM_WF){1'b0}}, pending_r};

    assign accept_s = fetch_valid & ~fifo_full_s & wfid_in_range(fetch_wfid)
                    & ~pending_ext_s[fetch_wfid]
                    & ~(flush_valid & (flush_wfid == fetch_wfid));

    // A same-cycle flush of the head's wavefront kills the return being popped.
    assign pop_s         = icache_ack & ~fifo_empty_s;
    assign head_killed_s = head_s.killed | (flush_valid & (flush_wfid == head_s.wfid));

    assign push_entry_s = '{wfid: fetch_wfid, pc: fetch_pc, killed: 1'b0};

    fetch_tracker_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (accept_s),
        .push_entry  (push_entry_s),
        .pop         (pop_s),
        .flush_valid (flush_valid),
        .flush_wfid  (flush_wfid),
        .head_entry  (head_s),
        .count       (fifo_count_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s)
    );

    // Pending bit per wavefront: set on accept, cleared when its entry pops
    // (killed or not), so a flushed wavefront waits for its stale return.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {NUM_WF{1'b0}};
        end else begin
            if (pop_s) begin
                pending_r[head_s.wfid] <= 1'b0;
            end
            if (accept_s) begin
                pending_r[fetch_wfid] <= 1'b1;
            end
        end
    end

    // Icache read strobe one cycle after accept; the address holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {PC_W{1'b0}};
        end else begin
            rd_en_r <= accept_s;
            if (accept_s) begin
                rd_addr_r <= fetch_pc;
            end
        end
    end

    // Registered instruction return; killed heads pop silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_r <= 1'b0;
            inst_wfid_r  <= {WF_ID_W{1'b0}};
            inst_pc_r    <= {PC_W{1'b0}};
        end else begin
            inst_valid_r <= pop_s & ~head_killed_s;
            if (pop_s) begin
                inst_wfid_r <= head_s.wfid;
                inst_pc_r   <= head_s.pc;
            end
        end
    end

    // Sticky flag for an acknowledge arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err_r <= 1'b0;
        end else if (icache_ack && fifo_empty_s) begin
            ack_err_r <= 1'b1;
        end
    end

`ifdef FETCH_TRACK_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_killed_r;
    logic [31:0] perf_stall_r;

    // Saturating event counters for accepts, killed pops and stalled requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_r <= 32'd0;
            perf_killed_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                perf_issued_r <= sat_inc32(perf_issued_r);
            end
            if (pop_s && head_killed_s) begin
                perf_killed_r <= sat_inc32(perf_killed_r);
            end
            if (fetch_valid && !accept_s) begin
                perf_stall_r <= sat_inc32(perf_stall_r);
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_killed = perf_killed_r;
    assign perf_stall  = perf_stall_r;
`endif

    assign fetch_accept   = accept_s;
    assign credit_ok      = (fifo_count_s != DEPTH_CNT);
    assign pending_mask   = pending_r;
    assign icache_rd_en   = rd_en_r;
    assign icache_rd_addr = rd_addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst_wfid      = inst_wfid_r;
    assign inst_pc        = inst_pc_r;
    assign ack_err        = ack_err_r;

endmodule

// File: tb/tb_fetch_req_tracker.sv
// Self-checking bench for fetch_req_tracker. A queue-based reference model
// derived from the behavioural rules predicts accept, issue, return,
// pending mask, credit and error outputs each cycle.
module tb_fetch_req_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [5:0]  fetch_wfid;
    logic [31:0] fetch_pc;
    logic        fetch_accept;
    logic        credit_ok;
    logic [39:0] pending_mask;
    logic        icache_rd_en;
    logic [31:0] icache_rd_addr;
    logic        icache_ack;
    logic        flush_valid;
    logic [5:0]  flush_wfid;
    logic        inst_valid;
    logic [5:0]  inst_wfid;
    logic [31:0] inst_pc;
    logic        ack_err;
`ifdef FETCH_TRACK_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_killed;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_req_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_wfid     (fetch_wfid),
        .fetch_pc       (fetch_pc),
        .fetch_accept   (fetch_accept),
        .credit_ok      (credit_ok),
        .pending_mask   (pending_mask),
        .icache_rd_en   (icache_rd_en),
        .icache_rd_addr (icache_rd_addr),
        .icache_ack     (icache_ack),
        .flush_valid    (flush_valid),
        .flush_wfid     (flush_wfid),
        .inst_valid     (inst_valid),
        .inst_wfid      (inst_wfid),
        .inst_pc        (inst_pc),
        .ack_err        (ack_err)
`ifdef FETCH_TRACK_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_killed    (perf_killed),
        .perf_stall     (perf_stall)
`endif
    );

    // Reference model state
    typedef struct {
        logic [5:0]  wfid;
        logic [31:0] pc;
        bit          killed;
    } ment_t;

    ment_t       mq[$];
    bit [39:0]   m_pend;
    bit          m_err;
    bit          e_rd_en;
    logic [31:0] e_rd_addr;
    bit          e_iv;
    logic [5:0]  e_iw;
    logic [31:0] e_ip;
    bit          obs_accept;
    bit          exp_accept;

    int tests_run    = 0;
    int tests_failed = 0;

    // Drive one clock cycle of inputs, sample fetch_accept before the edge,
    // then advance the model to match the registered state after the edge.
    task automatic cycle(input bit fv, input logic [5:0] fw, input logic [31:0] fp,
                         input bit ack, input bit flv, input logic [5:0] flw, input bit r);
        bit    acc;
        bit    k;
        ment_t h;
        @(negedge clk);
        fetch_valid = fv; fetch_wfid = fw; fetch_pc = fp;
        icache_ack = ack; flush_valid = flv; flush_wfid = flw; rst = r;
        #1;
        obs_accept = fetch_accept;
        acc = fv && (mq.size() < 8) && (fw < 6'd40) && !((fw < 6'd40) ? m_pend[fw] : 1'b0)
              && !(flv && (flw == fw));
        exp_accept = acc;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_pend = '0; m_err = 1'b0; e_rd_en = 1'b0; e_rd_addr = '0;
            e_iv = 1'b0; e_iw = '0; e_ip = '0;
        end else begin
            e_iv = 1'b0;
            if (ack) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h = mq.pop_front();
                    k = h.killed || (flv && (flw == h.wfid));
                    e_iv = !k; e_iw = h.wfid; e_ip = h.pc;
                    m_pend[h.wfid] = 1'b0;
                end
            end
            if (flv) begin
                foreach (mq[i]) if (mq[i].wfid == flw) mq[i].killed = 1'b1;
            end
            if (acc) begin
                mq.push_back('{fw, fp, 1'b0});
                m_pend[fw] = 1'b1;
                e_rd_en = 1'b1; e_rd_addr = fp;
            end else begin
                e_rd_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        tests_run++; if (credit_ok !== 1'b1) begin tests_failed++; $display("FAIL reset_credit got=%0b exp=1", credit_ok); end
        tests_run++; if (pending_mask !== 40'd0) begin tests_failed++; $display("FAIL reset_pending got=%h exp=0", pending_mask); end
        tests_run++; if ({icache_rd_en, inst_valid, ack_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=000", {icache_rd_en, inst_valid, ack_err}); end
        tests_run++; if ({icache_rd_addr, inst_pc, inst_wfid} !== 70'd0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", {icache_rd_addr, inst_pc, inst_wfid}); end
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (fetch_accept !== 1'b0) begin tests_failed++; $display("FAIL reset_accept got=%0b exp=0", fetch_accept); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 6'd5, 32'h100, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b1) begin tests_failed++; $display("FAIL basic_accept got=%0b exp=1", obs_accept); end
        tests_run++; if (icache_rd_en !== 1'b1 || icache_rd_addr !== 32'h100) begin tests_failed++; $display("FAIL basic_issue got=%0b/%h exp=1/100", icache_rd_en, icache_rd_addr); end
        tests_run++; if (pending_mask[5] !== 1'b1) begin tests_failed++; $display("FAIL basic_pend_set got=%0b exp=1", pending_mask[5]); end
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (inst_valid !== 1'b1 || inst_wfid !== 6'd5 || inst_pc !== 32'h100) begin tests_failed++; $display("FAIL basic_return got=%0b/%0d/%h exp=1/5/100", inst_valid, inst_wfid, inst_pc); end
        tests_run++; if (pending_mask[5] !== 1'b0 || icache_rd_en !== 1'b0) begin tests_failed++; $display("FAIL basic_pend_clr got=%0b/%0b exp=0/0", pending_mask[5], icache_rd_en); end
        tests_run++; if (icache_rd_addr !== 32'h100) begin tests_failed++; $display("FAIL basic_addr_hold got=%h exp=100", icache_rd_addr); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) cycle(1'b1, 6'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (credit_ok !== 1'b0) begin tests_failed++; $display("FAIL full_credit got=%0b exp=0", credit_ok); end
        cycle(1'b1, 6'd8, 32'h300, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b0) begin tests_failed++; $display("FAIL full_reject got=%0b exp=0", obs_accept); end
        tests_run++; if (credit_ok !== 1'b1 || inst_wfid !== 6'd0) begin tests_failed++; $display("FAIL full_pop got=%0b/%0d exp=1/0", credit_ok, inst_wfid); end
        cycle(1'b1, 6'd8, 32'h300, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b1) begin tests_failed++; $display("FAIL full_retry got=%0b exp=1", obs_accept); end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
            tests_run++; if (inst_valid !== 1'b1 || inst_wfid !== 6'(i)) begin tests_failed++; $display("FAIL full_drain got=%0b/%0d exp=1/%0d", inst_valid, inst_wfid, i); end
        end
    endtask

    task automatic test_double_fetch();
        cycle(1'b1, 6'd3, 32'h400, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b1, 6'd3, 32'h404, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b0) begin tests_failed++; $display("FAIL dbl_block got=%0b exp=0", obs_accept); end
        cycle(1'b1, 6'd3, 32'h404, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b0) begin tests_failed++; $display("FAIL dbl_block_ack got=%0b exp=0", obs_accept); end
        cycle(1'b1, 6'd3, 32'h404, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b1) begin tests_failed++; $display("FAIL dbl_reaccept got=%0b exp=1", obs_accept); end
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (inst_pc !== 32'h404) begin tests_failed++; $display("FAIL dbl_return got=%h exp=404", inst_pc); end
    endtask

    task automatic test_flush();
        cycle(1'b1, 6'd2, 32'h500, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b1, 6'd4, 32'h504, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 6'd2, 1'b0);
        cycle(1'b1, 6'd2, 32'h508, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b0 || pending_mask[2] !== 1'b1) begin tests_failed++; $display("FAIL flush_pend_hold got=%0b/%0b exp=0/1", obs_accept, pending_mask[2]); end
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (inst_valid !== 1'b0 || pending_mask[2] !== 1'b0) begin tests_failed++; $display("FAIL flush_drop got=%0b/%0b exp=0/0", inst_valid, pending_mask[2]); end
        cycle(1'b1, 6'd2, 32'h508, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b1 || inst_valid !== 1'b1 || inst_wfid !== 6'd4) begin tests_failed++; $display("FAIL flush_keep got=%0b/%0b/%0d exp=1/1/4", obs_accept, inst_valid, inst_wfid); end
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h508) begin tests_failed++; $display("FAIL flush_fresh got=%0b/%h exp=1/508", inst_valid, inst_pc); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 6'd6, 32'h600, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd6, 1'b0);
        tests_run++; if (inst_valid !== 1'b0 || pending_mask[6] !== 1'b0) begin tests_failed++; $display("FAIL sim_flush_ack got=%0b/%0b exp=0/0", inst_valid, pending_mask[6]); end
        cycle(1'b1, 6'd9, 32'h900, 1'b0, 1'b1, 6'd9, 1'b0);
        tests_run++; if (obs_accept !== 1'b0 || icache_rd_en !== 1'b0) begin tests_failed++; $display("FAIL sim_flush_fetch got=%0b/%0b exp=0/0", obs_accept, icache_rd_en); end
        cycle(1'b1, 6'd45, 32'h904, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (obs_accept !== 1'b0 || pending_mask !== 40'd0) begin tests_failed++; $display("FAIL sim_bad_wfid got=%0b/%h exp=0/0", obs_accept, pending_mask); end
    endtask

    task automatic test_error_reset();
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (ack_err !== 1'b1 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL err_set got=%0b/%0b exp=1/0", ack_err, inst_valid); end
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        tests_run++; if (ack_err !== 1'b1) begin tests_failed++; $display("FAIL err_hold got=%0b exp=1", ack_err); end
        for (int i = 10; i < 14; i++) cycle(1'b1, 6'(i), 32'h700 + 32'(i), 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b1);
        tests_run++; if (pending_mask !== 40'd0 || credit_ok !== 1'b1 || ack_err !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid got=%h/%0b/%0b/%0b exp=0/1/0/0", pending_mask, credit_ok, ack_err, inst_valid); end
        cycle(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tests_run++; if (ack_err !== 1'b1 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_discard got=%0b/%0b exp=1/0", ack_err, inst_valid); end
        cycle(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_random();
        bit          fv, ack, flv, r;
        logic [5:0]  fw, flw;
        logic [31:0] fp;
        for (int n = 0; n < 3000; n++) begin
            fv  = ($urandom_range(0, 9) < 7);
            fw  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 11));
            fp  = $urandom & 32'hFFFF_FFFC;
            ack = ($urandom_range(0, 9) < 4);
            flv = ($urandom_range(0, 9) == 0);
            flw = 6'($urandom_range(0, 11));
            r   = ($urandom_range(0, 199) == 0);
            cycle(fv, fw, fp, ack, flv, flw, r);
            if (!r) begin
                tests_run++; if (obs_accept !== exp_accept) begin tests_failed++; $display("FAIL rnd_accept n=%0d got=%0b exp=%0b", n, obs_accept, exp_accept); end
            end
            tests_run++; if (icache_rd_en !== e_rd_en || icache_rd_addr !== e_rd_addr) begin tests_failed++; $display("FAIL rnd_issue n=%0d got=%0b/%h exp=%0b/%h", n, icache_rd_en, icache_rd_addr, e_rd_en, e_rd_addr); end
            tests_run++; if (inst_valid !== e_iv) begin tests_failed++; $display("FAIL rnd_inst_valid n=%0d got=%0b exp=%0b", n, inst_valid, e_iv); end
            if (e_iv) begin
                tests_run++; if (inst_wfid !== e_iw || inst_pc !== e_ip) begin tests_failed++; $display("FAIL rnd_inst_data n=%0d got=%0d/%h exp=%0d/%h", n, inst_wfid, inst_pc, e_iw, e_ip); end
            end
            tests_run++; if (pending_mask !== m_pend) begin tests_failed++; $display("FAIL rnd_pending n=%0d got=%h exp=%h", n, pending_mask, m_pend); end
            tests_run++; if (credit_ok !== (mq.size() != 8) || ack_err !== m_err) begin tests_failed++; $display("FAIL rnd_credit_err n=%0d got=%0b/%0b exp=%0b/%0b", n, credit_ok, ack_err, mq.size() != 8, m_err); end
        end
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_wfid = 6'd0; fetch_pc = 32'd0;
        icache_ack = 1'b0; flush_valid = 1'b0; flush_wfid = 6'd0;
        m_pend = '0; m_err = 1'b0; e_rd_en = 1'b0; e_rd_addr = '0;
        e_iv = 1'b0; e_iw = '0; e_ip = '0;
        test_reset();
        test_basic();
        test_full();
        test_double_fetch();
        test_flush();
        test_simultaneous();
        test_error_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
